// File: rtl/float_to_fixed_pkg.sv
// Shared constants and state encoding for the float/fixed converter pair.
package float_to_fixed_pkg;

  localparam int          MANTISSA_SIZE = 23;
  localparam int          BIAS          = 127;
  localparam logic [7:0]  EXP_SPECIAL   = 8'd255;
  localparam logic [31:0] SAT_POS       = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG       = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SHIFT  = 3'd2,
    NEGATE = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Positive result means shift the 24-bit significand left, negative means right.
  function automatic logic signed [9:0] calc_shift(input logic [7:0] e, input logic [4:0] p);
    return $signed({2'b00, e}) + $signed({5'b00000, p}) - $signed(10'(BIAS + MANTISSA_SIZE));
  endfunction

endpackage

// File: rtl/float_to_fixed_unpack.sv
// Combinational field split and classification of an IEEE-754 single.
module float_unpack
  import float_to_fixed_pkg::*;
(
  input  logic [31:0]              flt,
  input  logic [4:0]               pos,
  output logic                     sign,
  output logic [MANTISSA_SIZE-1:0] man,
  output logic                     is_nan,
  output logic                     is_inf,
  output logic                     is_zero_or_denorm,
  output logic signed [9:0]        sh
);

  logic [7:0] expo_s;

  assign sign              = flt[31];
  assign expo_s            = flt[30:MANTISSA_SIZE];
  assign man               = flt[MANTISSA_SIZE-1:0];
  assign is_nan            = (expo_s == EXP_SPECIAL) && (man != '0);
  assign is_inf            = (expo_s == EXP_SPECIAL) && (man == '0);
  assign is_zero_or_denorm = (expo_s == 8'd0);
  assign sh                = calc_shift(expo_s, pos);

endmodule

// File: rtl/float_to_fixed.sv
// Iterative IEEE-754 single to 32-bit fixed-point converter: truncates toward
// zero, saturates on overflow, shifts the significand one bit per cycle.
module float_to_fixed
  import float_to_fixed_pkg::*;
#(
  parameter int FIXED_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            floatnumber,
  input  logic [4:0]             fixpointpos,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIXED_WIDTH-1:0] result,
  output logic                   overflow,
  output logic                   inexact,
  output logic                   invalid
);

  state_e state_r, state_s;

  logic [31:0]              flt_r;
  logic [4:0]               pos_r;
  logic [FIXED_WIDTH-1:0]   mag_r;
  logic [4:0]               cnt_r;
  logic                     left_r, sat_r, inx_r, inv_r;
  logic                     in_ready_r, out_valid_r;
  logic [FIXED_WIDTH-1:0]   result_r;
  logic                     overflow_r, inexact_r, invalid_r;

  logic                     sign_s, is_nan_s, is_inf_s, is_zd_s;
  logic [MANTISSA_SIZE-1:0] man_s;
  logic signed [9:0]        sh_s;

  logic [FIXED_WIDTH-1:0]   dec_mag_s;
  logic [4:0]               dec_cnt_s;
  logic                     dec_left_s, dec_sat_s, dec_inx_s, dec_inv_s;

  float_unpack u_unpack (
    .flt               (flt_r),
    .pos               (pos_r),
    .sign              (sign_s),
    .man               (man_s),
    .is_nan            (is_nan_s),
    .is_inf            (is_inf_s),
    .is_zero_or_denorm (is_zd_s),
    .sh                (sh_s)
  );

  // Classify the latched operand; special cases skip the shifter (count 0).
  always_comb begin
    dec_mag_s  = {{(FIXED_WIDTH-MANTISSA_SIZE-1){1'b0}}, 1'b1, man_s};
    dec_cnt_s  = 5'd0;
    dec_left_s = ~sh_s[9];
    dec_sat_s  = 1'b0;
    dec_inx_s  = 1'b0;
    dec_inv_s  = 1'b0;
    if (is_nan_s) begin
      dec_mag_s = '0;
      dec_inv_s = 1'b1;
    end else if (is_inf_s) begin
      dec_sat_s = 1'b1;
    end else if (is_zd_s) begin
      dec_mag_s = '0;
      dec_inx_s = (man_s != '0);
    end else if ((sh_s == 10'sd8) && sign_s && (man_s == '0)) begin
      // Exactly -2^31: negating 0x80000000 leaves it unchanged.
      dec_mag_s = SAT_NEG;
    end else if (sh_s > 10'sd7) begin
      dec_sat_s = 1'b1;
    end else if (sh_s < -10'sd24) begin
      dec_mag_s = '0;
      dec_inx_s = 1'b1;
    end else begin
      dec_cnt_s = sh_s[9] ? 5'(-sh_s) : 5'(sh_s);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = DECODE;
        else          state_s = IDLE;
      end
      DECODE: begin
        if (dec_cnt_s == 5'd0) state_s = NEGATE;
        else                   state_s = SHIFT;
      end
      SHIFT: begin
        if (cnt_r == 5'd1) state_s = NEGATE;
        else               state_s = SHIFT;
      end
      NEGATE: state_s = DONE;
      DONE: begin
        if (out_valid_r && out_ready) state_s = IDLE;
        else                          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Operand latch, decode capture and the bit-serial shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_r  <= 32'd0;
      pos_r  <= 5'd0;
      mag_r  <= '0;
      cnt_r  <= 5'd0;
      left_r <= 1'b0;
      sat_r  <= 1'b0;
      inx_r  <= 1'b0;
      inv_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            flt_r <= floatnumber;
            pos_r <= fixpointpos;
          end
        end
        DECODE: begin
          mag_r  <= dec_mag_s;
          cnt_r  <= dec_cnt_s;
          left_r <= dec_left_s;
          sat_r  <= dec_sat_s;
          inx_r  <= dec_inx_s;
          inv_r  <= dec_inv_s;
        end
        SHIFT: begin
          if (left_r) begin
            mag_r <= {mag_r[FIXED_WIDTH-2:0], 1'b0};
          end else begin
            mag_r <= {1'b0, mag_r[FIXED_WIDTH-1:1]};
            inx_r <= inx_r | mag_r[0];
          end
          cnt_r <= cnt_r - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Output registers: result loads in NEGATE, out_valid rises once in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r    <= '0;
      overflow_r  <= 1'b0;
      inexact_r   <= 1'b0;
      invalid_r   <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      in_ready_r <= (state_s == IDLE);
      case (state_r)
        NEGATE: begin
          if (sat_r)       result_r <= sign_s ? SAT_NEG : SAT_POS;
          else if (sign_s) result_r <= ~mag_r + 32'd1;
          else             result_r <= mag_r;
          overflow_r <= sat_r;
          inexact_r  <= inx_r;
          invalid_r  <= inv_r;
        end
        DONE: begin
          if (out_valid_r && out_ready) out_valid_r <= 1'b0;
          else                          out_valid_r <= 1'b1;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign overflow  = overflow_r;
  assign inexact   = inexact_r;
  assign invalid   = invalid_r;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed bench for float_to_fixed: hand-computed vectors, latency, backpressure,
// reset abort and integer round trips.
module tb_float_to_fixed;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] floatnumber;
  logic [4:0]  fixpointpos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, inexact, invalid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] f;
    logic [4:0]  p;
    logic [34:0] exp;  // {result, overflow, inexact, invalid}
    int          lat;
  } vec_t;

  float_to_fixed dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .floatnumber(floatnumber), .fixpointpos(fixpointpos),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .inexact(inexact), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Integer to IEEE single, exact for |x| < 2^24.
  function automatic logic [31:0] i2f(input int x);
    int a;
    int k;
    logic [31:0] r;
    if (x == 0) return 32'd0;
    a = (x < 0) ? -x : x;
    k = 0;
    for (int i = 0; i < 24; i++) if (a[i]) k = i;
    r[31]    = (x < 0);
    r[30:23] = 8'(127 + k);
    r[22:0]  = 23'(a << (23 - k));
    return r;
  endfunction

  task automatic start_req(input logic [31:0] f, input logic [4:0] p, output bit ok);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    ok = (in_ready === 1'b1);
    if (ok) begin
      floatnumber = f; fixpointpos = p; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!ok) begin
        @(posedge clk); #1; lat++;
        if (out_valid === 1'b1) ok = 1'b1;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    floatnumber = 32'd0; fixpointpos = 5'd0;
    #12;
    total++;
    if ({in_ready, out_valid, result, overflow, inexact, invalid} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset: got rdy=%b vld=%b res=%h flags=%b%b%b, want rdy=1 vld=0 res=0 flags=000",
               in_ready, out_valid, result, overflow, inexact, invalid);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    vec_t v[2];
    bit ok; int lat;
    v[0] = '{32'h40490FDB, 5'd16, {32'h0003243F, 3'b010}, 9};
    v[1] = '{32'hC0200000, 5'd8,  {32'hFFFFFD80, 3'b000}, 17};
    foreach (v[i]) begin
      start_req(v[i].f, v[i].p, ok);
      if (ok) wait_valid(lat, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL basic[%0d]: no handshake/out_valid within bound", i);
      end else begin
        if ({result, overflow, inexact, invalid} !== v[i].exp) begin
          bad++; $display("FAIL basic[%0d]: got %h want %h", i, {result, overflow, inexact, invalid}, v[i].exp);
        end
        total++;
        if (lat != v[i].lat) begin
          bad++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
        end
        release_out();
      end
    end
  endtask

  task automatic test_saturation();
    vec_t v[5];
    bit ok; int lat;
    v[0] = '{32'h4F000000, 5'd0,  {32'h7FFFFFFF, 3'b100}, 3};
    v[1] = '{32'hCF000000, 5'd0,  {32'h80000000, 3'b000}, 3};
    v[2] = '{32'h3F800000, 5'd31, {32'h7FFFFFFF, 3'b100}, 3};
    v[3] = '{32'h4EFFFFFF, 5'd0,  {32'h7FFFFF80, 3'b000}, 10};
    v[4] = '{32'h3F000000, 5'd0,  {32'h00000000, 3'b010}, 27};
    foreach (v[i]) begin
      start_req(v[i].f, v[i].p, ok);
      if (ok) wait_valid(lat, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL sat[%0d]: no handshake/out_valid within bound", i);
      end else begin
        if ({result, overflow, inexact, invalid} !== v[i].exp) begin
          bad++; $display("FAIL sat[%0d]: got %h want %h", i, {result, overflow, inexact, invalid}, v[i].exp);
        end
        total++;
        if (lat != v[i].lat) begin
          bad++; $display("FAIL sat_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
        end
        release_out();
      end
    end
  endtask

  task automatic test_specials();
    vec_t v[5];
    bit ok; int lat;
    v[0] = '{32'h7FC00000, 5'd16, {32'h00000000, 3'b001}, 3};
    v[1] = '{32'hFF800000, 5'd16, {32'h80000000, 3'b100}, 3};
    v[2] = '{32'h00000001, 5'd16, {32'h00000000, 3'b010}, 3};
    v[3] = '{32'h3E800000, 5'd0,  {32'h00000000, 3'b010}, 3};
    v[4] = '{32'h80000000, 5'd16, {32'h00000000, 3'b000}, 3};
    foreach (v[i]) begin
      start_req(v[i].f, v[i].p, ok);
      if (ok) wait_valid(lat, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL special[%0d]: no handshake/out_valid within bound", i);
      end else begin
        if ({result, overflow, inexact, invalid} !== v[i].exp) begin
          bad++; $display("FAIL special[%0d]: got %h want %h", i, {result, overflow, inexact, invalid}, v[i].exp);
        end
        total++;
        if (lat != v[i].lat) begin
          bad++; $display("FAIL special_lat[%0d]: got %0d want %0d", i, lat, v[i].lat);
        end
        release_out();
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    start_req(32'hC0200000, 5'd8, ok);
    if (ok) wait_valid(lat, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL backpressure: no handshake/out_valid within bound");
    end else begin
      for (int c = 0; c < 5; c++) begin
        floatnumber = 32'h3F800000; fixpointpos = 5'd16; in_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready, result, overflow, inexact, invalid} !== {2'b10, 32'hFFFFFD80, 3'b000}) begin
          bad++;
          $display("FAIL hold[%0d]: got vld=%b rdy=%b res=%h flags=%b%b%b want vld=1 rdy=0 res=fffffd80 flags=000",
                   c, out_valid, in_ready, result, overflow, inexact, invalid);
        end
      end
      in_valid = 1'b0;
      release_out();
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++; $display("FAIL release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++; $display("FAIL ignored_req: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit ok; int lat;
    start_req(32'h40490FDB, 5'd16, ok);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, result} !== {2'b01, 32'd0}) begin
      bad++; $display("FAIL abort: got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=0", out_valid, in_ready, result);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    start_req(32'h3F800000, 5'd16, ok);
    if (ok) wait_valid(lat, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL after_abort: no handshake/out_valid within bound");
    end else begin
      if ({result, overflow, inexact, invalid} !== {32'h00010000, 3'b000} || lat != 10) begin
        bad++; $display("FAIL after_abort: got %h lat=%0d want %h lat=10",
                        {result, overflow, inexact, invalid}, lat, {32'h00010000, 3'b000});
      end
      release_out();
    end
  endtask

  task automatic test_round_trip();
    int xs[12];
    bit ok; int lat;
    xs[0] = 1; xs[1] = -1; xs[2] = 16777215; xs[3] = -16777215; xs[4] = 0;
    for (int i = 5; i < 12; i++) begin
      xs[i] = int'($urandom_range(0, 32'h00FFFFFF));
      if ($urandom_range(0, 1) == 1) xs[i] = -xs[i];
    end
    foreach (xs[i]) begin
      start_req(i2f(xs[i]), 5'd0, ok);
      if (ok) wait_valid(lat, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL roundtrip[%0d]: no handshake/out_valid within bound", i);
      end else begin
        if ({result, overflow, inexact, invalid} !== {xs[i], 3'b000}) begin
          bad++; $display("FAIL roundtrip[%0d]: x=%0d got %h want %h", i, xs[i],
                          {result, overflow, inexact, invalid}, {xs[i], 3'b000});
        end
        release_out();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_specials();
    test_backpressure();
    test_reset_abort();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_to_fixed.md
Name: float_to_fixed

Overview:
- Iterative converter from IEEE-754 single-precision to 32-bit two's-complement fixed point, with a caller-selected binary point position.
- Inverse companion of the fixed-to-float converter; sits on the same datapath for round-trip checks.
- Uses a valid/ready handshake on both sides and a one-bit-per-cycle shifter, so latency varies with exponent distance.
- Truncates toward zero and saturates on overflow.

Parameters:
- MANTISSA_SIZE, 23, stored fraction bits.
- BIAS, 127, exponent bias.
- FIXED_WIDTH, 32, output word width (only 32 supported).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  request carries a number to convert
- in_ready  output  1  converter can accept; high only in IDLE
- floatnumber  input  32  IEEE-754 single; latched on acceptance
- fixpointpos  input  5  fraction bits in result; latched on acceptance
- out_valid  output  1  result and flags valid; held until out_ready
- out_ready  input  1  consumer accepts result
- result  output  32  two's-complement fixed value
- overflow  output  1  saturated (|value| out of range, or ±Inf)
- inexact  output  1  nonzero bits discarded (truncation, underflow, denormal flush)
- invalid  output  1  input was NaN

Behaviour:
- Reset (rst=0, async): state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0. Reset mid-conversion aborts the conversion with no output.
- Accept: handshake when in_valid && in_ready at a clock edge. Latch sign s, exponent e, mantissa m and fixpointpos p. Move to DECODE.
- DECODE:
  - Compute mag = {1,m} (24b, held in a 32b reg).
  - Compute sh = e - 150 + p, signed 10b.
  - Classify the input:
    - e==255, m!=0: result=0, invalid=1.
    - e==255, m==0: saturate, overflow=1.
    - e==0: result=0; inexact=(m!=0).
    - sh>8, or sh==8 with !(s && m==0): saturate, overflow=1.
    - sh==8 && s && m==0: result=0x80000000 exact.
    - sh<-24: result=0, inexact=1.
  - Special cases go to NEGATE with shift count 0. Otherwise go to SHIFT with count n=|sh| and direction sign(sh). If n==0, go directly to NEGATE.
- SHIFT: one bit per cycle; decrement count; exit to NEGATE when count reaches 0.
  - Left shift: sh ≤ 7 cannot overflow, since 24+7=31 bits.
  - Right shift: OR each bit shifted out into sticky inexact.
- NEGATE: if s, result = ~mag+1; otherwise result = mag. Saturation values: positive 0x7FFFFFFF, negative 0x80000000.
- DONE: out_valid=1, with result and flags stable.
  - out_valid && out_ready at an edge returns to IDLE, and out_valid drops.
  - A new request is accepted no earlier than the edge after return to IDLE (in_ready rises in IDLE). There is no overlap.
- Latency: out_valid rises 3+n edges after the accept edge (n=0 for special cases). Worst case 27 edges.
- -0.0 gives result 0, all flags 0.
- in_valid while busy is ignored. The requester must hold its inputs until accepted.

Decomposition:
- Shared package: MANTISSA_SIZE, BIAS, EXP_SPECIAL=255, SAT_POS=32'h7FFFFFFF, SAT_NEG=32'h80000000, and the state encoding IDLE/DECODE/SHIFT/NEGATE/DONE. This package is shared with the fixed-to-float converter.
- One sub-module, float_unpack (combinational): field split, is_nan, is_inf, is_zero_or_denorm, and signed sh computation.

Test Plan:
1. 0x40490FDB (π), p=16 -> result 0x0003243F, inexact=1, other flags 0, out_valid 9 edges after accept.
2. 0xC0200000 (-2.5), p=8 -> result 0xFFFFFD80, all flags 0, latency 17 edges.
3. Saturation boundary:
   - 0x4F000000, p=0 -> 0x7FFFFFFF, overflow=1.
   - 0xCF000000, p=0 -> 0x80000000, overflow=0.
   - 0x3F800000, p=31 -> 0x7FFFFFFF, overflow=1.
4. Specials:
   - 0x7FC00000 -> 0, invalid=1.
   - 0xFF800000 -> 0x80000000, overflow=1.
   - 0x00000001 -> 0, inexact=1.
   - 0x3E800000, p=0 -> 0, inexact=1.
   - 0x80000000 -> 0, all flags 0.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result, flags and out_valid stable; in_ready=0; a new in_valid is ignored. Raise out_ready -> IDLE next edge.
6. Reset and round-trip:
   - Assert rst mid-SHIFT (input 0x40490FDB, p=16) -> immediate out_valid=0, in_ready=1. The next request 0x3F800000, p=16 -> 0x00010000, with no residue from the aborted conversion.
   - Random round-trip: fixed-to-float then back, for integers |x|<2^24 -> exact match.
